// File: rtl/prog_loader_pkg.sv
// Shared types and default geometry for the program page loader.
package prog_loader_pkg;

    localparam int unsigned PAGE_W_DEF = 7;
    localparam int unsigned OFS_W_DEF  = 8;
    localparam int unsigned DATA_W_DEF = 16;
    localparam int unsigned PAGE_WORDS = 32'd1 << OFS_W_DEF;

    // Loader sequencing: wait for a request, burst the page in, report completion.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/prog_page_loader_if.sv
// Upstream control, CPU fetch and external memory signals of the page loader.
// The master side (control unit / CPU / memory model) drives requests and
// read data; the slave side is the loader itself.
interface prog_page_loader_if
    import prog_loader_pkg::*;
#(
    parameter int unsigned PAGE_W = PAGE_W_DEF,
    parameter int unsigned OFS_W  = OFS_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) ();

    logic [PAGE_W-1:0]       p1_page;
    logic                    p1_reset;
    logic                    p1_prefetch;
    logic                    p1_req;
    logic                    p1_ready;
    logic [OFS_W-1:0]        cpu_addr;
    logic                    cpu_rd;
    logic [DATA_W-1:0]       cpu_data;
    logic                    cpu_hit;
    logic                    mem_req;
    logic [PAGE_W+OFS_W-1:0] mem_addr;
    logic                    mem_ack;
    logic [DATA_W-1:0]       mem_data;

    modport master (
        output p1_page, p1_reset, p1_prefetch, cpu_addr, cpu_rd, mem_ack, mem_data,
        input  p1_req, p1_ready, cpu_data, cpu_hit, mem_req, mem_addr
    );

    modport slave (
        input  p1_page, p1_reset, p1_prefetch, cpu_addr, cpu_rd, mem_ack, mem_data,
        output p1_req, p1_ready, cpu_data, cpu_hit, mem_req, mem_addr
    );

endinterface

// File: rtl/prog_page_ram.sv
// Page buffer: simple dual-port synchronous RAM, one write port fed by the
// fill engine and one registered read port serving CPU fetches.
module prog_page_ram #(
    parameter int unsigned OFS_W  = 8,
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en_i,
    input  logic [OFS_W-1:0]  wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd_en_i,
    input  logic [OFS_W-1:0]  rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o
);

    localparam int unsigned DEPTH = 32'd1 << OFS_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rd_data_q;

    // Storage array: written one word per accepted memory beat, no reset.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Read register: holds the last fetched word, cleared by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q <= {DATA_W{1'b0}};
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/prog_page_loader.sv
// Program page loader: burst-loads a 2^OFS_W-word program page from external
// memory into a local buffer and serves CPU fetches from it.
// Optional feature macro PROG_LOADER_AUTO_FILL_EN: a CPU read that misses
// while idle starts a fill of the requested page, exactly like p1_prefetch.
module prog_page_loader
    import prog_loader_pkg::*;
#(
    parameter int unsigned PAGE_W = PAGE_W_DEF,
    parameter int unsigned OFS_W  = OFS_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic          clk,
    input  logic          rst,
    prog_page_loader_if.slave bus
);

    state_e                  state_q, state_d;
    logic [PAGE_W-1:0]       fill_page_q, fill_page_d;
    logic [PAGE_W-1:0]       loaded_page_q, loaded_page_d;
    logic [OFS_W-1:0]        ofs_q, ofs_d;
    logic                    valid_q, valid_d;
    logic                    abort_q, abort_d;
    logic                    p1_req_q, p1_req_d;
    logic                    p1_ready_q, p1_ready_d;
    logic                    mem_req_q, mem_req_d;
    logic [PAGE_W+OFS_W-1:0] mem_addr_q, mem_addr_d;
    logic                    cpu_hit_q, cpu_hit_d;

    logic                    start_s;
    logic                    auto_start_s;
    logic                    wr_en_s;
    logic [OFS_W-1:0]        ofs_inc_s;
    logic [DATA_W-1:0]       rd_data_s;

`ifdef PROG_LOADER_AUTO_FILL_EN
    // A fetch that misses the buffer requests the page it asked for.
    always_comb begin
        auto_start_s = bus.cpu_rd & (~valid_q | (loaded_page_q != bus.p1_page));
    end
`else
    // Without auto-fill, misses never start a load.
    always_comb begin
        auto_start_s = 1'b0;
    end
`endif

    // Sequencer next state: fill start/abort/completion and buffer bookkeeping.
    always_comb begin
        state_d       = state_q;
        fill_page_d   = fill_page_q;
        loaded_page_d = loaded_page_q;
        ofs_d         = ofs_q;
        valid_d       = valid_q;
        abort_d       = abort_q;
        mem_addr_d    = mem_addr_q;
        wr_en_s       = 1'b0;
        start_s       = bus.p1_prefetch | auto_start_s;
        ofs_inc_s     = ofs_q + {{(OFS_W-1){1'b0}}, 1'b1};

        case (state_q)
            ST_IDLE: begin
                if (bus.p1_reset) begin
                    // Invalidate has priority over any load request.
                    valid_d = 1'b0;
                end else if (start_s) begin
                    state_d     = ST_FILL;
                    fill_page_d = bus.p1_page;
                    ofs_d       = {OFS_W{1'b0}};
                    valid_d     = 1'b0;
                    abort_d     = 1'b0;
                    mem_addr_d  = {bus.p1_page, {OFS_W{1'b0}}};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FILL: begin
                if (bus.p1_reset) begin
                    // Abort: finish through DONE so upstream still sees a completion.
                    abort_d = 1'b1;
                    state_d = ST_DONE;
                end else if (bus.mem_ack && mem_req_q) begin
                    wr_en_s    = 1'b1;
                    ofs_d      = ofs_inc_s;
                    mem_addr_d = {fill_page_q, ofs_inc_s};
                    if (ofs_q == {OFS_W{1'b1}}) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_FILL;
                    end
                end else begin
                    state_d = ST_FILL;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                if (!abort_q) begin
                    valid_d       = 1'b1;
                    loaded_page_d = fill_page_q;
                end else begin
                    valid_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
            end
        endcase

        p1_req_d   = (state_d == ST_FILL);
        mem_req_d  = (state_d == ST_FILL);
        p1_ready_d = (state_d != ST_DONE);
        cpu_hit_d  = bus.cpu_rd & valid_q & (loaded_page_q == bus.p1_page) & (state_q == ST_IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            fill_page_q   <= {PAGE_W{1'b0}};
            loaded_page_q <= {PAGE_W{1'b0}};
            ofs_q         <= {OFS_W{1'b0}};
            valid_q       <= 1'b0;
            abort_q       <= 1'b0;
            p1_req_q      <= 1'b0;
            p1_ready_q    <= 1'b1;
            mem_req_q     <= 1'b0;
            mem_addr_q    <= {(PAGE_W+OFS_W){1'b0}};
            cpu_hit_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            fill_page_q   <= fill_page_d;
            loaded_page_q <= loaded_page_d;
            ofs_q         <= ofs_d;
            valid_q       <= valid_d;
            abort_q       <= abort_d;
            p1_req_q      <= p1_req_d;
            p1_ready_q    <= p1_ready_d;
            mem_req_q     <= mem_req_d;
            mem_addr_q    <= mem_addr_d;
            cpu_hit_q     <= cpu_hit_d;
        end
    end

    prog_page_ram #(
        .OFS_W  (OFS_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (wr_en_s),
        .wr_addr_i (ofs_q),
        .wr_data_i (bus.mem_data),
        .rd_en_i   (bus.cpu_rd),
        .rd_addr_i (bus.cpu_addr),
        .rd_data_o (rd_data_s)
    );

    assign bus.p1_req   = p1_req_q;
    assign bus.p1_ready = p1_ready_q;
    assign bus.mem_req  = mem_req_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.cpu_hit  = cpu_hit_q;
    assign bus.cpu_data = rd_data_s;

endmodule

// File: tb/tb_prog_page_loader.sv
// Bench for prog_page_loader: directed scenarios plus random traffic, all
// checked against a transaction-level model of the page buffer.
module tb_prog_page_loader;
    import prog_loader_pkg::*;

    localparam int PW = 7;
    localparam int OW = 8;
    localparam int DW = 16;
`ifdef PROG_LOADER_AUTO_FILL_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [DW-1:0] salt = 16'h0000;
    bit   run_cmp = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   ready_lo_total = 0;

    always #5 clk = ~clk;

    prog_page_loader_if #(.PAGE_W(PW), .OFS_W(OW), .DATA_W(DW)) bus ();

    prog_page_loader #(.PAGE_W(PW), .OFS_W(OW), .DATA_W(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [DW-1:0] pattern(input logic [PW+OW-1:0] a);
        return {1'b0, a} ^ 16'hA5A5;
    endfunction

    assign bus.mem_data = pattern(bus.mem_addr) ^ salt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [DW-1:0] m_buf [0:255];
    logic          m_busy, m_done, m_abort, m_valid;
    logic [PW-1:0] m_page, m_loaded;
    logic [OW-1:0] m_cnt;
    logic          e_hit;
    logic [DW-1:0] e_data;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 1'b0; m_done <= 1'b0; m_abort <= 1'b0; m_valid <= 1'b0;
            m_page <= '0; m_loaded <= '0; m_cnt <= '0; e_hit <= 1'b0; e_data <= '0;
        end else begin
            e_hit <= bus.cpu_rd && m_valid && (m_loaded == bus.p1_page) && !m_busy && !m_done;
            if (bus.cpu_rd) e_data <= m_buf[bus.cpu_addr];
            if (m_done) begin
                m_done <= 1'b0;
                if (!m_abort) begin
                    m_valid  <= 1'b1;
                    m_loaded <= m_page;
                end
            end else if (m_busy) begin
                if (bus.p1_reset) begin
                    m_abort <= 1'b1; m_busy <= 1'b0; m_done <= 1'b1;
                end else if (bus.mem_ack) begin
                    m_buf[m_cnt] <= bus.mem_data;
                    m_cnt <= m_cnt + 8'd1;
                    if (m_cnt == 8'hFF) begin
                        m_busy <= 1'b0; m_done <= 1'b1;
                    end
                end
            end else if (bus.p1_reset) begin
                m_valid <= 1'b0;
            end else if (bus.p1_prefetch ||
                         (AUTO && bus.cpu_rd && (!m_valid || m_loaded != bus.p1_page))) begin
                m_busy <= 1'b1; m_page <= bus.p1_page; m_cnt <= 8'd0;
                m_valid <= 1'b0; m_abort <= 1'b0;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (!rst && run_cmp) begin
            check("p1_req",   {31'd0, bus.p1_req},   {31'd0, m_busy});
            check("p1_ready", {31'd0, bus.p1_ready}, {31'd0, !m_done});
            check("mem_req",  {31'd0, bus.mem_req},  {31'd0, m_busy});
            check("mem_addr", {17'd0, bus.mem_addr}, {17'd0, m_page, m_cnt});
            check("cpu_hit",  {31'd0, bus.cpu_hit},  {31'd0, e_hit});
            if (e_hit) check("cpu_data", {16'd0, bus.cpu_data}, {16'd0, e_data});
            if (!bus.p1_ready) ready_lo_total++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic go();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [OW-1:0] a);
        bus.cpu_addr = a;
        bus.cpu_rd   = 1'b1;
        @(posedge clk);
        #1;
        bus.cpu_rd = 1'b0;
        @(negedge clk);
        #1;
    endtask

    // Waits for the completion pulse; called right after the start was sampled.
    task automatic wait_fill(input int budget, input int period, output int lo_at,
                             output int req_cnt, output int first_a, output int last_a);
        lo_at = 0; req_cnt = 0; first_a = -1; last_a = -1;
        for (int k = 1; k <= budget; k++) begin
            @(negedge clk);
            if (bus.p1_req) begin
                if (req_cnt == 0) first_a = int'(bus.mem_addr);
                last_a = int'(bus.mem_addr);
                req_cnt++;
            end
            if (!bus.p1_ready) begin
                lo_at = k;
                break;
            end
            if (period > 1) bus.mem_ack = ((k % period) == (period - 1));
        end
        check("fill_timeout", {31'd0, (lo_at != 0)}, 32'd1);
    endtask

    task automatic settle();
        go();
        if (bus.p1_req) begin
            bus.p1_reset = 1'b1;
            go();
            bus.p1_reset = 1'b0;
        end
        go();
        go();
    endtask

    task automatic start_fill(input logic [PW-1:0] pg);
        bus.p1_page     = pg;
        bus.p1_prefetch = 1'b1;
        go();
        bus.p1_prefetch = 1'b0;
    endtask

    int lo_at, req_cnt, first_a, last_a, hits, lo_before;
    bit found;

    initial begin
        bus.p1_page = '0; bus.p1_reset = 1'b0; bus.p1_prefetch = 1'b0;
        bus.cpu_addr = '0; bus.cpu_rd = 1'b0; bus.mem_ack = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_p1_req",   {31'd0, bus.p1_req},   32'd0);
        check("rst_p1_ready", {31'd0, bus.p1_ready}, 32'd1);
        check("rst_mem_req",  {31'd0, bus.mem_req},  32'd0);
        check("rst_mem_addr", {17'd0, bus.mem_addr}, 32'd0);
        check("rst_cpu_data", {16'd0, bus.cpu_data}, 32'd0);
        check("rst_cpu_hit",  {31'd0, bus.cpu_hit},  32'd0);
        go();
        rst = 1'b0;
        run_cmp = 1'b1;
        go();

        // Full fill of page 5 with ack held high.
        bus.mem_ack = 1'b1;
        start_fill(7'h05);
        wait_fill(400, 1, lo_at, req_cnt, first_a, last_a);
        check("t1_ready_lo_at", lo_at, 32'd257);
        check("t1_req_cycles",  req_cnt, 32'd256);
        check("t1_first_addr",  first_a, 32'h0500);
        check("t1_last_addr",   last_a,  32'h05FF);
        bus.mem_ack = 1'b0;
        go();
        rd(8'h3C);
        check("t2_hit",  {31'd0, bus.cpu_hit},  32'd1);
        check("t2_data", {16'd0, bus.cpu_data}, 32'hA099);
        bus.p1_page = 7'h06;
        rd(8'h3C);
        check("t2_page_change_hit", {31'd0, bus.cpu_hit}, 32'd0);
        settle();

        // Fill with an ack every third cycle.
        salt = 16'h3C3C;
        lo_before = ready_lo_total;
        start_fill(7'h09);
        wait_fill(1200, 3, lo_at, req_cnt, first_a, last_a);
        bus.mem_ack = 1'b0;
        repeat (6) go();
        check("t3_ready_pulses", ready_lo_total - lo_before, 32'd1);
        hits = 0;
        for (int a = 0; a < 256; a++) begin
            rd(8'(a));
            if (bus.cpu_hit) hits++;
        end
        check("t3_hits", hits, 32'd256);
        settle();

        // Invalidate mid-fill at offset 0x40.
        salt = 16'h1111;
        bus.mem_ack = 1'b1;
        lo_before = ready_lo_total;
        start_fill(7'h0A);
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            if (bus.p1_req && bus.mem_addr[7:0] == 8'h40) begin
                bus.p1_reset = 1'b1;
                go();
                bus.p1_reset = 1'b0;
                found = 1'b1;
            end else begin
                go();
            end
        end
        check("t4_found_0x40", {31'd0, found}, 32'd1);
        @(negedge clk);
        check("t4_mem_req_drop", {31'd0, bus.mem_req},  32'd0);
        check("t4_ready_low",    {31'd0, bus.p1_ready}, 32'd0);
        bus.mem_ack = 1'b0;
        repeat (4) go();
        check("t4_ready_pulses", ready_lo_total - lo_before, 32'd1);
        rd(8'h10);
        check("t4_hit_after_abort", {31'd0, bus.cpu_hit}, 32'd0);
        settle();

        // Reset and prefetch together in IDLE, with a valid page present.
        salt = 16'h2222;
        bus.mem_ack = 1'b1;
        start_fill(7'h05);
        wait_fill(400, 1, lo_at, req_cnt, first_a, last_a);
        bus.mem_ack = 1'b0;
        go();
        rd(8'h3C);
        check("t5_hit_before", {31'd0, bus.cpu_hit}, 32'd1);
        bus.p1_reset = 1'b1;
        bus.p1_prefetch = 1'b1;
        go();
        bus.p1_reset = 1'b0;
        bus.p1_prefetch = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t5_no_fill", {31'd0, bus.mem_req}, 32'd0);
        end
        go();
        rd(8'h3C);
        check("t5_hit_after", {31'd0, bus.cpu_hit}, 32'd0);
        settle();

        // Miss with invalid buffer: auto-fill or plain miss.
        bus.p1_page = 7'h12;
        rd(8'h00);
        check("t6_hit", {31'd0, bus.cpu_hit}, 32'd0);
        if (AUTO) begin
            check("t6_p1_req_auto",   {31'd0, bus.p1_req},   32'd1);
            check("t6_mem_addr_auto", {17'd0, bus.mem_addr}, 32'h1200);
            bus.mem_ack = 1'b1;
            wait_fill(400, 1, lo_at, req_cnt, first_a, last_a);
            bus.mem_ack = 1'b0;
        end else begin
            check("t6_p1_req_noauto",  {31'd0, bus.p1_req},  32'd0);
            check("t6_mem_req_noauto", {31'd0, bus.mem_req}, 32'd0);
        end
        settle();

        // Random traffic against the model.
        bus.p1_page = 7'h03;
        for (int c = 0; c < 6000; c++) begin
            bus.p1_prefetch = ($urandom_range(0, 149) == 0);
            bus.p1_reset    = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 299) == 0) bus.p1_page = 7'($urandom_range(3, 4));
            bus.cpu_rd   = $urandom_range(0, 1) == 1;
            bus.cpu_addr = 8'($urandom);
            bus.mem_ack  = $urandom_range(0, 1) == 1;
            salt         = 16'($urandom);
            go();
        end
        bus.p1_prefetch = 1'b0; bus.p1_reset = 1'b0; bus.cpu_rd = 1'b0; bus.mem_ack = 1'b0;
        repeat (3) go();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/prog_page_loader.md
# prog_page_loader

Program-space page buffer that sits directly downstream of the memory subsystem control unit. It consumes the program page number and the reset/prefetch strobes, burst-loads the selected 256-word page from external memory into a local buffer RAM, and serves CPU instruction fetches from that buffer. It reports transaction status back upstream on `p1_req`/`p1_ready`.

## Interface
- `PAGE_W`, 7: program page number width.
- `OFS_W`, 8: word-offset width; the page holds 2^OFS_W words.
- `DATA_W`, 16: word width.
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `p1_page` in PAGE_W: requested program page.
- `p1_reset` in 1: invalidate strobe (level, sampled each cycle).
- `p1_prefetch` in 1: load-page strobe.
- `p1_req` out 1: high from fill start through the last accepted word.
- `p1_ready` out 1: 1 at rest; a single-cycle low pulse marks fill completion.
- `cpu_addr` in OFS_W: fetch offset.
- `cpu_rd` in 1: fetch strobe.
- `cpu_data` out DATA_W: fetched word, registered.
- `cpu_hit` out 1: `cpu_data` valid for the current page.
- `mem_req` out 1: external read request.
- `mem_addr` out PAGE_W+OFS_W: {latched page, offset}.
- `mem_ack` in 1: word accepted; `mem_data` valid this cycle.
- `mem_data` in DATA_W: external read data.

## Operation
- States: IDLE, FILL, DONE.
- IDLE:
  - `p1_prefetch` → latch `fill_page` = `p1_page`, offset = 0, clear `valid`, go to FILL.
  - `p1_reset` → clear `valid`. If `p1_reset` and `p1_prefetch` are both high, reset wins and no fill starts.
- FILL: `mem_req` = 1, `p1_req` = 1.
  - On each `mem_ack`, write `mem_data` to buffer[offset] and increment offset (OFS_W bits, wraps).
  - The ack at offset 2^OFS_W−1 → DONE.
  - `p1_prefetch` during FILL is ignored.
  - `p1_reset` during FILL aborts: drop `mem_req`, keep `valid` = 0, go to DONE. This is out of the upstream contract, but it must not deadlock.
- DONE (one cycle): `p1_ready` = 0, `p1_req` = 0, `mem_req` = 0. Set `valid` = 1 and `loaded_page` = `fill_page` unless the fill was aborted. Return to IDLE.
- Fetch: on `cpu_rd`, read buffer[`cpu_addr`]. Next cycle, `cpu_data` = word and `cpu_hit` = `valid` & (`loaded_page` == `p1_page`) & (state == IDLE), all sampled at `cpu_rd`. With no `cpu_rd`, `cpu_hit` = 0.
- A page change on `p1_page` with no prefetch only drops `cpu_hit`; the buffer contents are kept.

## Timing
- Reset values: `p1_req` 0, `p1_ready` 1, `mem_req` 0, `mem_addr` 0, `cpu_data` 0, `cpu_hit` 0, state IDLE, `valid` 0, `loaded_page` 0.
- `p1_req` rises the cycle after `p1_prefetch` is sampled.
- Full fill with `mem_ack` held high: FILL lasts 256 cycles, then one DONE cycle. `p1_ready` low exactly 257 cycles after the prefetch sample.
- `mem_addr` is registered and updates the cycle after each ack. `mem_ack` while `mem_req` = 0 is ignored.
- Fetch latency: 1 cycle. A read of offset k in the first IDLE cycle after DONE returns the filled word with `cpu_hit` = 1.

## Configuration
- `PROG_LOADER_AUTO_FILL_EN` defined: in IDLE, `cpu_rd` with `valid` = 0 or `loaded_page` ≠ `p1_page` starts a fill of `p1_page`, exactly as `p1_prefetch` does. The missed read returns `cpu_hit` = 0.
- Not defined: misses only return `cpu_hit` = 0; fills start solely on `p1_prefetch`.

## Structure
- Package `prog_loader_pkg`:
  - state enum (IDLE/FILL/DONE);
  - default PAGE_W/OFS_W/DATA_W constants;
  - a `PAGE_WORDS` constant.
- Sub-module `prog_page_ram`: simple dual-port synchronous RAM, 2^OFS_W × DATA_W, with a write port (fill) and a registered read port (CPU).

## Test plan
- Reset, then `p1_prefetch` with `p1_page` = 0x05 and `mem_ack` held high → `mem_addr` sweeps 0x0500..0x05FF; `p1_ready` low for one cycle 257 cycles later; `p1_req` high for 256 cycles.
- After that fill, read `cpu_addr` = 0x3C → next cycle `cpu_data` = pattern(0x053C) and `cpu_hit` = 1. Change `p1_page` to 0x06 and read again → `cpu_hit` = 0.
- Fill with `mem_ack` asserted every third cycle → all 256 words are correct and `p1_ready` pulses once, after the final ack.
- `p1_reset` at offset 0x40 mid-fill → `mem_req` drops the next cycle, `p1_ready` pulses low once, and subsequent reads give `cpu_hit` = 0.
- `p1_reset` and `p1_prefetch` in the same IDLE cycle → no fill (`mem_req` stays 0), `valid` = 0.
- With `PROG_LOADER_AUTO_FILL_EN`: `cpu_rd` with `valid` = 0 and `p1_page` = 0x12 → a fill of page 0x12 starts and `p1_req` rises one cycle later. Without the macro: no fill starts and `cpu_hit` = 0.
